lnvd_feedback_mixer: RTL

Parametrised, pipelined N-channel feedback mixer for the LNVD audio path. Each sample, it combines ADC samples with the attenuated output of the process delay buffer in a selectable mode. It saturates, rounds to the DAC/output width, and reports per-channel clipping plus a running clip count. It sits between the ADC capture / delay-buffer stage and the output formatter.

---
 rtl/lnvd_feedback_mixer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lnvd_feedback_mixer.sv
// N-channel feedback mixer: pass/add/subtract attenuated delay-buffer feedback,
// clamp to the input range, round to the output width, and track clipping.
module lnvd_feedback_mixer #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned IN_W     = 12,
   parameter int unsigned OUT_W    = 8,
   parameter int unsigned FB_SHIFT = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CHANNELS*IN_W-1:0]  data_in,
   input  logic [CHANNELS*IN_W-1:0]  fb_in,
   input  logic [1:0]                mode,
   input  logic                      clip_clear,
   output logic                      out_valid,
   output logic [CHANNELS*OUT_W-1:0] data_out,
   output logic [CHANNELS-1:0]       sat_flags,
   output logic [15:0]               clip_count
);

   localparam int unsigned SW    = IN_W + 2;
   localparam int unsigned RW    = IN_W + 1;
   localparam int unsigned RSW   = OUT_W + 1;
   localparam int unsigned DROP  = IN_W - OUT_W;
   localparam int unsigned CNT_W = 16;

   localparam logic [SW-1:0] IN_MAX = {2'b00, {IN_W{1'b1}}};
   localparam logic [RW-1:0] HALF   = RW'(1) << (DROP - 1);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_ADD  = 2'b01,
      MODE_SUB  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   logic [CHANNELS-1:0][SW-1:0]    s1_d, s1_q;
   logic                           v1_q;
   logic [CHANNELS-1:0][IN_W-1:0]  c2_d, c2_q;
   logic [CHANNELS-1:0]            f2_d, f2_q;
   logic                           v2_q;
   logic [CHANNELS-1:0][RW-1:0]    r_c;
   logic [CHANNELS-1:0][RSW-1:0]   rs_c;
   logic [CHANNELS-1:0][OUT_W-1:0] q_d;
   logic [CHANNELS-1:0]            fl_d;
   logic                           any_clip_c;

   // Stage 1: signed mix of live sample with attenuated feedback
   always_comb begin
      s1_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         case (mode_e'(mode))
            MODE_ADD: s1_d[k] = SW'(data_in[k*IN_W +: IN_W])
                              + SW'(fb_in[k*IN_W +: IN_W] >> FB_SHIFT);
            MODE_SUB: s1_d[k] = SW'(data_in[k*IN_W +: IN_W])
                              - SW'(fb_in[k*IN_W +: IN_W] >> FB_SHIFT);
            default:  s1_d[k] = SW'(data_in[k*IN_W +: IN_W]);
         endcase
      end
   end

   // Stage 2: clamp into [0, 2^IN_W-1]; the sign bit marks an underflow
   always_comb begin
      c2_d = '0;
      f2_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (s1_q[k][SW-1]) begin
            c2_d[k] = '0;
            f2_d[k] = 1'b1;
         end else if (s1_q[k] > IN_MAX) begin
            c2_d[k] = '1;
            f2_d[k] = 1'b1;
         end else begin
            c2_d[k] = s1_q[k][IN_W-1:0];
         end
      end
   end

   // Output stage: round half-up; a carry into bit OUT_W saturates the code
   always_comb begin
      r_c  = '0;
      rs_c = '0;
      q_d  = '0;
      fl_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         r_c[k]  = RW'(c2_q[k]) + HALF;
         rs_c[k] = RSW'(r_c[k] >> DROP);
         if (rs_c[k][OUT_W]) begin
            q_d[k]  = '1;
            fl_d[k] = 1'b1;
         end else begin
            q_d[k]  = rs_c[k][OUT_W-1:0];
         end
         fl_d[k] = fl_d[k] | f2_q[k];
      end
   end

   assign any_clip_c = |fl_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         s1_q       <= '0;
         v2_q       <= 1'b0;
         c2_q       <= '0;
         f2_q       <= '0;
         out_valid  <= 1'b0;
         data_out   <= '0;
         sat_flags  <= '0;
         clip_count <= '0;
      end else begin
         v1_q      <= in_valid;
         v2_q      <= v1_q;
         out_valid <= v2_q;
         if (in_valid) s1_q <= s1_d;
         if (v1_q) begin
            c2_q <= c2_d;
            f2_q <= f2_d;
         end
         if (v2_q) begin
            data_out  <= q_d;
            sat_flags <= fl_d;
         end
         // Clear wins over a coincident count; one count per clipped sample
         if (clip_clear) begin
            clip_count <= '0;
         end else if (v2_q && any_clip_c && (clip_count != {CNT_W{1'b1}})) begin
            clip_count <= clip_count + CNT_W'(1);
         end
      end
   end

endmodule
